// File: rtl/adquisicion_sensores_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adquisicion_sensores_pkg
// Brief    : Shared FSM encoding, ADC frame layout and temperature helper
//            for the sensor acquisition front end.
// Revision : 1.0 - initial release
// ============================================================================
package adquisicion_sensores_pkg;

  // Acquisition FSM states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_PUBLISH  = 3'd4
  } estado_t;

  // ADC frame layout: 16 bits, the 8-bit code sits in [11:4]
  localparam int FRAME_BITS = 16;
  localparam int CODE_MSB   = 11;
  localparam int CODE_LSB   = 4;
  localparam int CODE_BITS  = CODE_MSB - CODE_LSB + 1;
  localparam int TEMP_BITS  = 5;

  // Published temperature is the top five bits of the code (truncation)
  function automatic logic [TEMP_BITS-1:0] temp_from_frame(
    input logic [FRAME_BITS-1:0] frame
  );
    logic [CODE_BITS-1:0] code;
    code = frame[CODE_MSB:CODE_LSB];
    return code[CODE_BITS-1:CODE_BITS-TEMP_BITS];
  endfunction

endpackage
`default_nettype wire

// File: rtl/adquisicion_sensores_antirrebote.sv
`default_nettype none
// ============================================================================
// Module   : antirrebote
// Brief    : Two-flop synchronizer followed by a counter debouncer for one
//            asynchronous contact. 'changed' pulses in the cycle before the
//            stable value flips.
// Revision : 1.0 - initial release
// ============================================================================
module antirrebote #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic changed
);

  localparam int                CNT_W   = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchronize the raw contact and count consecutive cycles of disagreement
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    changed  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        changed  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/adquisicion_sensores.sv
`default_nettype none
// ============================================================================
// Module   : adquisicion_sensores
// Brief    : Sensor front end. Periodically reads a serial temperature ADC as
//            SPI-style master, debounces presence/ignition contacts and
//            publishes all three with a one-cycle datos_listos strobe.
// Revision : 1.0 - initial release
// ============================================================================
module adquisicion_sensores #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000000,
  parameter int DEB_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adc_miso,
  input  logic       presencia_raw,
  input  logic       ignicion_raw,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic [4:0] temperatura,
  output logic       presencia,
  output logic       ignicion,
  output logic       datos_listos
);

  import adquisicion_sensores_pkg::*;

  localparam int               TMR_W    = $clog2(SAMPLE_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  estado_t               state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic                  high_q, high_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  pending_q, pending_d;
  logic [TEMP_BITS-1:0]  temp_q, temp_d;
  logic                  pres_q, pres_d;
  logic                  ign_q, ign_d;

  logic tick;
  logic phase_end;
  logic in_frame;
  logic pres_stable, pres_changed;
  logic ign_stable, ign_changed;

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_presencia (
    .clk     (clk),
    .rst     (rst),
    .raw     (presencia_raw),
    .stable  (pres_stable),
    .changed (pres_changed)
  );

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ignicion (
    .clk     (clk),
    .rst     (rst),
    .raw     (ignicion_raw),
    .stable  (ign_stable),
    .changed (ign_changed)
  );

  // Free-running period tick and end-of-phase decode
  always_comb begin
    tick      = (timer_q == TMR_LAST);
    phase_end = (div_cnt_q == DIV_LAST);
    in_frame  = (state_q == ST_CS_SETUP) || (state_q == ST_SHIFT) ||
                (state_q == ST_CS_HOLD);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: a tick beats a pending contact change in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (tick)           state_d = ST_CS_SETUP;
        else if (pending_q) state_d = ST_PUBLISH;
      end
      ST_CS_SETUP: if (phase_end) state_d = ST_SHIFT;
      ST_SHIFT:    if (phase_end && high_q && bit_cnt_q == BIT_LAST) state_d = ST_CS_HOLD;
      ST_CS_HOLD:  if (phase_end) state_d = ST_PUBLISH;
      ST_PUBLISH:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: chip select spans the whole frame, sclk only in SHIFT
  always_comb begin
    adc_cs_n     = !in_frame;
    adc_sclk     = (state_q == ST_SHIFT) && high_q;
    datos_listos = (state_q == ST_PUBLISH);
  end

  // Datapath: timers, bit shifter, pending flag and published values
  always_comb begin
    timer_d   = tick ? '0 : timer_q + 1'b1;
    div_cnt_d = '0;
    high_d    = 1'b0;
    bit_cnt_d = '0;
    shift_d   = shift_q;
    pending_d = pending_q;
    temp_d    = temp_q;
    pres_d    = pres_q;
    ign_d     = ign_q;

    if (in_frame && !phase_end) div_cnt_d = div_cnt_q + 1'b1;

    if (state_q == ST_SHIFT) begin
      high_d    = high_q;
      bit_cnt_d = bit_cnt_q;
      if (phase_end) begin
        high_d = !high_q;
        // Sample at the end of the high phase, MSB first
        if (high_q) begin
          shift_d   = {shift_q[FRAME_BITS-2:0], adc_miso};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    end

    // A change landing on the publish edge stays pending for a later strobe
    if (state_d == ST_PUBLISH) pending_d = 1'b0;
    if (pres_changed || ign_changed) pending_d = 1'b1;

    if (state_d == ST_PUBLISH) begin
      pres_d = pres_stable;
      ign_d  = ign_stable;
      if (state_q == ST_CS_HOLD) temp_d = temp_from_frame(shift_q);
    end
  end

  // Datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      timer_q   <= '0;
      div_cnt_q <= '0;
      high_q    <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      pending_q <= 1'b0;
      temp_q    <= '0;
      pres_q    <= 1'b0;
      ign_q     <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      div_cnt_q <= div_cnt_d;
      high_q    <= high_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      pending_q <= pending_d;
      temp_q    <= temp_d;
      pres_q    <= pres_d;
      ign_q     <= ign_d;
    end
  end

  assign temperatura = temp_q;
  assign presencia   = pres_q;
  assign ignicion    = ign_q;

endmodule
`default_nettype wire

// File: tb/tb_adquisicion_sensores.sv
`default_nettype none
// ============================================================================
// Module   : tb_adquisicion_sensores
// Brief    : Directed self-checking bench for adquisicion_sensores with a
//            behavioural serial ADC and strobe/sclk/cs monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adquisicion_sensores;

  localparam int CD  = 4;
  localparam int SP  = 400;
  localparam int DEB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       adc_miso;
  logic       presencia_raw;
  logic       ignicion_raw;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic [4:0] temperatura;
  logic       presencia;
  logic       ignicion;
  logic       datos_listos;

  logic [15:0] frame;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;
  int rise_cnt = 0;
  int cs_low_cnt = 0;
  int back2back = 0;

  adquisicion_sensores #(
    .CLK_DIV       (CD),
    .SAMPLE_PERIOD (SP),
    .DEB_CYCLES    (DEB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .adc_miso      (adc_miso),
    .presencia_raw (presencia_raw),
    .ignicion_raw  (ignicion_raw),
    .adc_cs_n      (adc_cs_n),
    .adc_sclk      (adc_sclk),
    .temperatura   (temperatura),
    .presencia     (presencia),
    .ignicion      (ignicion),
    .datos_listos  (datos_listos)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the index of the last posedge
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: bit 15 presented while deselected, next bit after each sclk fall
  initial begin
    int  bit_idx;
    logic prev;
    bit_idx  = 15;
    prev     = 1'b0;
    adc_miso = 1'b0;
    forever begin
      @(negedge clk);
      if (adc_cs_n) begin
        bit_idx  = 15;
        adc_miso = frame[15];
      end else if (prev && !adc_sclk && bit_idx > 0) begin
        bit_idx  = bit_idx - 1;
        adc_miso = frame[bit_idx];
      end
      prev = adc_sclk;
    end
  end

  // Monitors for strobes, sclk rising edges and chip-select low time
  initial begin
    logic prev_sclk, prev_dl;
    prev_sclk = 1'b0;
    prev_dl   = 1'b0;
    forever begin
      @(negedge clk);
      if (datos_listos) strobe_cnt = strobe_cnt + 1;
      if (datos_listos && prev_dl) back2back = back2back + 1;
      if (adc_sclk && !prev_sclk) rise_cnt = rise_cnt + 1;
      if (!adc_cs_n) cs_low_cnt = cs_low_cnt + 1;
      prev_sclk = adc_sclk;
      prev_dl   = datos_listos;
    end
  end

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks = n_checks + 1;
    if (obs !== exp_v) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic wait_strobe(input string tag, input int max_cyc, output int at);
    bit ok;
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (datos_listos) begin
        ok = 1'b1;
        at = cyc;
      end
    end
    check(tag, int'(ok), 1);
  endtask

  task automatic wait_cs_low(input string tag, input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (!adc_cs_n) ok = 1'b1;
    end
    check(tag, int'(ok), 1);
  endtask

  initial begin
    int rst_cyc, at, c0, s0, r0, l0;
    rst           = 1'b0;
    presencia_raw = 1'b0;
    ignicion_raw  = 1'b0;
    frame         = 16'h0A50;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cs_n", int'(adc_cs_n), 1);
    check("rst_sclk", int'(adc_sclk), 0);
    check("rst_temp", int'(temperatura), 0);
    check("rst_pres", int'(presencia), 0);
    check("rst_ign", int'(ignicion), 0);
    check("rst_dl", int'(datos_listos), 0);

    // Test 1: first frame 0x0A50; tick cycle T = rst_cyc + SP - 1
    rst_cyc = cyc;
    rst     = 1'b1;
    r0 = rise_cnt;
    l0 = cs_low_cnt;
    wait_strobe("t1_strobe", SP + 200, at);
    check("t1_latency", at - (rst_cyc + SP - 1), 137);
    check("t1_temp", int'(temperatura), 20);
    check("t1_pres", int'(presencia), 0);
    check("t1_ign", int'(ignicion), 0);
    @(negedge clk);
    check("t1_strobe_width", int'(datos_listos), 0);
    check("t1_sclk_rises", rise_cnt - r0, 16);
    check("t1_cs_low", cs_low_cnt - l0, 136);

    // Test 2: extreme codes
    frame = 16'hFFFF;
    wait_strobe("t2a_strobe", SP + 50, at);
    check("t2a_temp", int'(temperatura), 31);
    frame = 16'h0000;
    wait_strobe("t2b_strobe", SP + 50, at);
    check("t2b_temp", int'(temperatura), 0);

    // Test 5: presence change during a frame merges into its publish
    frame = 16'h0C80;
    wait_cs_low("t5_cs_fall", SP + 50);
    @(negedge clk);
    presencia_raw = 1'b1;
    s0 = strobe_cnt;
    wait_strobe("t5_strobe", 200, at);
    check("t5_temp", int'(temperatura), 25);
    check("t5_pres", int'(presencia), 1);
    repeat (40) @(negedge clk);
    check("t5_one_strobe", strobe_cnt - s0, 1);

    // Presence release in IDLE: stand-alone publish, temperature held
    presencia_raw = 1'b0;
    wait_strobe("t5b_strobe", 40, at);
    check("t5b_pres", int'(presencia), 0);
    check("t5b_temp", int'(temperatura), 25);

    // Test 3: presence raise in IDLE, latency 2 + DEB + 1 (+/-1)
    repeat (5) @(negedge clk);
    s0 = strobe_cnt;
    c0 = cyc;
    presencia_raw = 1'b1;
    wait_strobe("t3_strobe", 40, at);
    check("t3_latency_window", int'((at - c0) >= DEB + 2 && (at - c0) <= DEB + 4), 1);
    check("t3_pres", int'(presencia), 1);
    check("t3_temp", int'(temperatura), 25);
    repeat (40) @(negedge clk);
    check("t3_one_strobe", strobe_cnt - s0, 1);

    // Test 4: ignition chatter shorter than DEB never gets through
    frame = 16'h0A50;
    wait_strobe("t4_frame_strobe", SP + 50, at);
    check("t4_frame_temp", int'(temperatura), 20);
    @(negedge clk);
    s0 = strobe_cnt;
    for (int i = 0; i < 40; i++) begin
      repeat (5) @(negedge clk);
      ignicion_raw = ~ignicion_raw;
    end
    ignicion_raw = 1'b0;
    repeat (30) @(negedge clk);
    check("t4_no_strobe", strobe_cnt - s0, 0);
    check("t4_ign", int'(ignicion), 0);

    // Test 6: reset during SHIFT bit 7 aborts the frame
    wait_cs_low("t6_cs_fall", SP + 50);
    repeat (CD + 16 * CD + 2 - 1) @(negedge clk);
    check("t6_pre_cs_low", int'(adc_cs_n), 0);
    check("t6_pre_pres", int'(presencia), 1);
    rst           = 1'b0;
    presencia_raw = 1'b0;
    frame         = 16'h0B30;
    @(negedge clk);
    check("t6_cs_n", int'(adc_cs_n), 1);
    check("t6_sclk", int'(adc_sclk), 0);
    check("t6_temp", int'(temperatura), 0);
    check("t6_pres", int'(presencia), 0);
    check("t6_ign", int'(ignicion), 0);
    check("t6_dl", int'(datos_listos), 0);
    repeat (2) @(negedge clk);
    rst_cyc = cyc;
    s0 = strobe_cnt;
    rst = 1'b1;
    wait_strobe("t6_strobe", SP + 200, at);
    check("t6_latency", at - (rst_cyc + SP - 1), 137);
    check("t6_frame_temp", int'(temperatura), 22);
    @(negedge clk);
    check("t6_single_strobe", strobe_cnt - s0, 1);

    check("no_back_to_back", back2back, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
